// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter family: control states and the
// output round/saturate helper used when narrowing an accumulator.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  // Working width of the round/saturate helper; wide enough for any accumulator.
  localparam int SAT_W = 64;

  function automatic int addr_width(input int taps);
    return (taps > 32'sd1) ? $clog2(taps) : 32'sd1;
  endfunction

  // Round half up by 2^(shift-1), arithmetic shift right, clamp to a signed out_w range.
  function automatic logic signed [SAT_W-1:0] round_sat(
    input logic signed [SAT_W-1:0] val,
    input int unsigned             shift,
    input int unsigned             out_w
  );
    logic signed [SAT_W-1:0] one_s;
    logic signed [SAT_W-1:0] half_s;
    logic signed [SAT_W-1:0] rnd_s;
    logic signed [SAT_W-1:0] shf_s;
    logic signed [SAT_W-1:0] max_s;
    logic signed [SAT_W-1:0] min_s;
    logic signed [SAT_W-1:0] res_s;
    one_s = 64'sd1;
    if (shift > 32'd0) begin
      half_s = one_s <<< (shift - 32'd1);
    end else begin
      half_s = 64'sd0;
    end
    rnd_s = val + half_s;
    shf_s = rnd_s >>> shift;
    max_s = (one_s <<< (out_w - 32'd1)) - one_s;
    min_s = -(one_s <<< (out_w - 32'd1));
    if (shf_s > max_s) begin
      res_s = max_s;
    end else if (shf_s < min_s) begin
      res_s = min_s;
    end else begin
      res_s = shf_s;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// Runtime-writable coefficient store: synchronous write, combinational read,
// cleared by reset.
module fir_coef_ram
  import fir_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int COEF_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] mem_r [TAPS];

  // Coefficient array: cleared on reset, one entry written per strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one shared multiply-accumulate walks all taps,
// with valid/ready handshakes, a writable coefficient RAM and rounded, saturated output.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 32,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  x_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [OUT_W-1:0]   y_n,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      coef_err
);

  localparam int ADDR_W = addr_width(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  fir_state_e               state_r;
  logic signed [DATA_W-1:0] dline_r [TAPS];
  logic [ADDR_W-1:0]        wr_ptr_r;
  logic [ADDR_W-1:0]        rd_ptr_r;
  logic [ADDR_W-1:0]        tap_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [OUT_W-1:0]  y_r;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic                     coef_err_r;

  logic                     accept_s;
  logic                     coef_addr_ok_s;
  logic                     coef_wr_s;
  logic                     coef_bad_s;
  logic [COEF_W-1:0]        coef_rd_raw_s;
  logic signed [COEF_W-1:0] coef_rd_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [OUT_W-1:0]  y_next_s;
  logic [ADDR_W-1:0]        wr_next_s;
  logic [ADDR_W-1:0]        rd_prev_s;

  // Only non-power-of-two tap counts can address past the last coefficient.
  if ((32'd1 << ADDR_W) == TAPS) begin : g_addr_full
    assign coef_addr_ok_s = 1'b1;
  end else begin : g_addr_range
    localparam logic [ADDR_W:0] TAPS_EXT = (ADDR_W + 1)'(TAPS);
    assign coef_addr_ok_s = ({1'b0, coef_addr} < TAPS_EXT);
  end

  fir_coef_ram #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .ADDR_W (ADDR_W)
  ) u_coef_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_wr_s),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (tap_r),
    .rdata (coef_rd_raw_s)
  );

  assign coef_rd_s = coef_rd_raw_s;

  // Handshake and write qualification, pointer wrap, and the shared MAC datapath.
  always_comb begin
    accept_s   = (state_r == IDLE) && in_valid;
    coef_wr_s  = 1'b0;
    coef_bad_s = 1'b0;
    if (coef_we) begin
      if ((state_r == IDLE) && coef_addr_ok_s) begin
        coef_wr_s = 1'b1;
      end else begin
        coef_bad_s = 1'b1;
      end
    end else begin
      coef_wr_s  = 1'b0;
      coef_bad_s = 1'b0;
    end
    if (wr_ptr_r == LAST_TAP) begin
      wr_next_s = '0;
    end else begin
      wr_next_s = wr_ptr_r + ADDR_W'(1);
    end
    if (rd_ptr_r == '0) begin
      rd_prev_s = LAST_TAP;
    end else begin
      rd_prev_s = rd_ptr_r - ADDR_W'(1);
    end
    prod_s     = PROD_W'(coef_rd_s) * PROD_W'(dline_r[rd_ptr_r]);
    acc_next_s = acc_r + ACC_W'(prod_s);
    y_next_s   = OUT_W'(round_sat(SAT_W'(acc_next_s), OUT_SHIFT, OUT_W));
  end

  // Control FSM, delay line, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        dline_r[i] <= '0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      tap_r       <= '0;
      acc_r       <= '0;
      y_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      coef_err_r  <= 1'b0;
    end else begin
      coef_err_r <= coef_bad_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dline_r[wr_ptr_r] <= x_n;
            wr_ptr_r          <= wr_next_s;
            rd_ptr_r          <= wr_ptr_r;
            tap_r             <= '0;
            acc_r             <= '0;
            in_ready_r        <= 1'b0;
            state_r           <= MAC;
          end
        end
        MAC: begin
          // rd_ptr walks backwards from the newest sample, so tap k meets x[n-k].
          acc_r    <= acc_next_s;
          tap_r    <= tap_r + ADDR_W'(1);
          rd_ptr_r <= rd_prev_s;
          if (tap_r == LAST_TAP) begin
            y_r         <= y_next_s;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r & ~rst;
  assign out_valid = out_valid_r;
  assign y_n       = y_r;
  assign coef_err  = coef_err_r;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench: two filters (OUT_SHIFT 0 and 1) share stimulus and are compared
// every cycle against a sum-of-products model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_fir_serial_mac;

  localparam int TAPS = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [7:0]  x_n = 8'sd0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic               coef_we = 1'b0;
  logic [4:0]         coef_addr = 5'd0;
  logic signed [7:0]  coef_wdata = 8'sd0;

  logic               in_ready_a, out_valid_a, coef_err_a;
  logic               in_ready_b, out_valid_b, coef_err_b;
  logic signed [15:0] y_a, y_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_serial_mac #(.OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .x_n(x_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .y_n(y_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_a)
  );

  fir_serial_mac #(.OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .x_n(x_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .y_n(y_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_b)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  h_m [TAPS];
  int  hist [TAPS];
  bit  live = 1'b0;
  bit  busy = 1'b0;
  int  t_since = 0;
  bit  err_exp = 1'b0;
  int  exp0_q [$];
  int  exp1_q [$];

  // floor((v + round) / 2^shift), clamped to the 16-bit signed range
  function automatic int scale_sat(input int v, input int shift);
    int d, q, w;
    d = 1 << shift;
    w = (shift > 0) ? v + d / 2 : v;
    q = w / d;
    if ((w % d != 0) && (w < 0)) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic model_step();
    int acc;
    if (rst) begin
      live = 1'b1;
      foreach (h_m[i]) h_m[i] = 0;
      foreach (hist[i]) hist[i] = 0;
      busy = 1'b0;
      t_since = 0;
      err_exp = 1'b0;
      exp0_q.delete();
      exp1_q.delete();
    end else if (live) begin
      err_exp = 1'b0;
      if (coef_we) begin
        if (!busy && int'(coef_addr) < TAPS) h_m[coef_addr] = int'(coef_wdata);
        else err_exp = 1'b1;
      end
      if (!busy) begin
        if (in_valid) begin
          for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = int'(x_n);
          acc = 0;
          for (int k = 0; k < TAPS; k++) acc += h_m[k] * hist[k];
          exp0_q.push_back(scale_sat(acc, 0));
          exp1_q.push_back(scale_sat(acc, 1));
          busy = 1'b1;
          t_since = 0;
        end
      end else if (t_since >= TAPS && out_ready) begin
        busy = 1'b0;
        void'(exp0_q.pop_front());
        void'(exp1_q.pop_front());
      end else if (t_since < TAPS) begin
        t_since++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // every-cycle comparison, away from the active edge
  initial forever begin
    @(negedge clk);
    if (live) begin
      check("in_ready0", in_ready_a, !busy && !rst);
      check("in_ready1", in_ready_b, !busy && !rst);
      check("out_valid0", out_valid_a, busy && t_since >= TAPS);
      check("out_valid1", out_valid_b, busy && t_since >= TAPS);
      check("coef_err0", coef_err_a, err_exp);
      check("coef_err1", coef_err_b, err_exp);
      if (busy && t_since >= TAPS && exp0_q.size() > 0) begin
        check("y_shift0", y_a, exp0_q[0]);
        check("y_shift1", y_b, exp1_q[0]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1;
    coef_addr = 5'(addr);
    coef_wdata = 8'(val);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int x);
    bit done;
    done = 1'b0;
    x_n = 8'(x);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        done = 1'b1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    coef_we = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic recv(output int y0, output int y1, output int lat);
    bit done;
    done = 1'b0;
    y0 = 0;
    y1 = 0;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (out_valid_a) begin
        lat = i;
        y0 = int'(y_a);
        y1 = int'(y_b);
        done = 1'b1;
        break;
      end
    end
    if (!done) check("recv_timeout", 0, 1);
    else tick();
  endtask

  initial begin
    int y0, y1, lat;
    bit seen;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_y", y_a, 0);
    check("rst_coef_err", coef_err_a, 0);

    // impulse response, h[k] = k-16
    for (int k = 0; k < TAPS; k++) write_coef(k, k - 16);
    for (int i = 0; i < TAPS; i++) begin
      send((i == 0) ? 1 : 0);
      recv(y0, y1, lat);
      check("impulse", y0, i - 16);
      if (i == 0) check("latency", lat, 33);
    end

    // saturation in both directions
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    for (int i = 0; i < TAPS; i++) begin
      send(127);
      recv(y0, y1, lat);
    end
    check("sat_pos0", y0, 32767);
    check("sat_pos1", y1, 32767);
    for (int i = 0; i < TAPS; i++) begin
      send(-128);
      recv(y0, y1, lat);
    end
    check("sat_neg0", y0, -32768);
    check("sat_neg1", y1, -32768);

    // rounding with OUT_SHIFT=1, h[0]=3 only
    write_coef(0, 3);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0);
    send(1);  recv(y0, y1, lat); check("round_x1", y1, 2);  check("plain_x1", y0, 3);
    send(-1); recv(y0, y1, lat); check("round_xm1", y1, -1);
    send(2);  recv(y0, y1, lat); check("round_x2", y1, 3);

    // backpressure with a held input sample
    out_ready = 1'b0;
    send(1);
    x_n = 8'sd5;
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid_a) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y_hold", y_a, 3);
      check("bp_in_ready", in_ready_a, 0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_idle_gap", in_ready_a, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", in_ready_a, 0);
    recv(y0, y1, lat);
    check("bp_next_y", y0, 15);

    // coefficient writes: rejected while busy, honoured with a simultaneous sample
    send(1);
    repeat (4) tick();
    coef_we = 1'b1;
    coef_addr = 5'd0;
    coef_wdata = 8'sd100;
    tick();
    coef_we = 1'b0;
    @(negedge clk);
    check("cw_err_pulse", coef_err_a, 1);
    @(negedge clk);
    check("cw_err_clear", coef_err_a, 0);
    recv(y0, y1, lat);
    check("cw_unchanged", y0, 3);
    coef_we = 1'b1;
    coef_addr = 5'd0;
    coef_wdata = 8'sd5;
    send(1);
    recv(y0, y1, lat);
    check("cw_same_edge", y0, 5);

    // reset in the middle of the MAC
    send(1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready_a, 1);
    check("mid_rst_y", y_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_a) seen = 1'b1;
    end
    check("mid_rst_no_output", seen, 0);
    send(1); recv(y0, y1, lat); check("cleared_0", y0, 0);
    send(0); recv(y0, y1, lat); check("cleared_1", y0, 0);
    send(0); recv(y0, y1, lat); check("cleared_2", y0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
